// File: rtl/frame_writer_pkg.sv
// frame_writer_pkg: shared types and widths for the frame writer.
//   state_t  - capture FSM states
//   PIX_W    - RGB888 pixel width
//   DATA_W   - memory write-data width
//   entry_w  - width of one FIFO entry {address, pixel}
package frame_writer_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DRAIN} state_t;
    localparam int PIX_W  = 24;
    localparam int DATA_W = 32;
    function automatic int entry_w(input int addr_w);
        return addr_w + PIX_W;
    endfunction
endpackage

// File: rtl/frame_writer_if.sv
// frame_writer_if: Avalon-MM-style write bus between the frame writer and memory.
//   address     - word address of the write
//   writedata   - {8'h00, R, G, B}
//   write       - write request
//   waitrequest - slave stall; address/data are held while high
interface frame_writer_if #(parameter int ADDR_W = 20);
    import frame_writer_pkg::*;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              write;
    logic              waitrequest;
    modport master(output address, writedata, write, input waitrequest);
    modport slave(input address, writedata, write, output waitrequest);
endinterface

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous first-word-fall-through FIFO with a registered head.
//   i_clk/i_rst_n - clock, asynchronous active-low reset
//   i_push/i_din  - write request and entry
//   i_pop         - read request (ignored when empty)
//   o_dout        - head entry, read straight from the storage registers
//   o_full/o_empty- occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module pix_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_pop;
    logic             w_push;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/frame_writer.sv
// frame_writer: places captured RGB888 pixels into a linear frame buffer.
//   i_pclk/i_rst_n - pixel clock, asynchronous active-low reset
//   i_enable       - arm capture; only looked at on frame boundaries
//   i_frame_base   - word address of pixel (0,0), latched at frame start
//   i_vsync        - high during vertical blanking
//   i_hsync        - one-cycle pulse at the start of each line
//   i_din/i_din_valid - pixel {R,G,B} and its one-cycle strobe
//   avm            - Avalon-MM write master
//   o_frame_done   - one-cycle pulse once the last write of a frame is done
//   o_overflow     - sticky: an in-range pixel was dropped on a full FIFO
//   o_clipped      - sticky: a pixel fell outside the active window
//   o_busy         - capturing or draining a frame
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              i_pclk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_frame_base,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic [PIX_W-1:0]  i_din,
    input  logic              i_din_valid,
    frame_writer_if.master    avm,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic              o_clipped,
    output logic              o_busy
);
    localparam int EW = entry_w(ADDR_W);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    state_t            r_state;
    logic              r_vsync_d;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_frame_done;
    logic              r_overflow;
    logic              r_clipped;
    logic              r_busy;
    logic              w_adv;
    logic [XW-1:0]     w_x_eff;
    logic [XW-1:0]     w_x_next;
    logic [YW-1:0]     w_y_eff;
    logic [ADDR_W-1:0] w_lb_eff;
    logic [ADDR_W-1:0] w_addr;
    logic              w_in_range;
    logic              w_take;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [EW-1:0]     w_head;
    // A line advance takes effect before a pixel strobed in the same cycle,
    // so all pixel decisions use the post-advance x/y/line_base.
    assign w_adv      = (r_state == ACTIVE) & i_hsync & (r_x != '0);
    assign w_x_eff    = w_adv ? '0 : r_x;
    assign w_y_eff    = (w_adv && r_y != YW'(V_ACTIVE)) ? r_y + YW'(1) : r_y;
    assign w_lb_eff   = w_adv ? r_line_base + ADDR_W'(H_ACTIVE) : r_line_base;
    assign w_in_range = (w_x_eff < XW'(H_ACTIVE)) & (w_y_eff < YW'(V_ACTIVE));
    assign w_take     = (r_state == ACTIVE) & i_din_valid;
    assign w_push     = w_take & w_in_range;
    // x keeps counting past the line end, saturating at H_ACTIVE.
    assign w_x_next   = (w_take && w_x_eff != XW'(H_ACTIVE)) ? w_x_eff + XW'(1) : w_x_eff;
    // Address by accumulation: line_base steps by H_ACTIVE per line.
    assign w_addr     = w_lb_eff + ADDR_W'(w_x_eff);
    assign w_pop      = avm.write & ~avm.waitrequest;
    pix_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_pclk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   ({w_addr, i_din}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    assign avm.address   = w_head[EW-1:PIX_W];
    assign avm.writedata = {{(DATA_W-PIX_W){1'b0}}, w_head[PIX_W-1:0]};
    assign avm.write     = ~w_empty;
    assign o_frame_done  = r_frame_done;
    assign o_overflow    = r_overflow;
    assign o_clipped     = r_clipped;
    assign o_busy        = r_busy;
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_vsync_d    <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_line_base  <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_clipped    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_vsync_d    <= i_vsync;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: if (i_enable && i_vsync) r_state <= WAIT_FRAME;
                WAIT_FRAME: if (r_vsync_d && !i_vsync) begin
                    r_state     <= ACTIVE;
                    r_busy      <= 1'b1;
                    r_x         <= '0;
                    r_y         <= '0;
                    r_line_base <= i_frame_base;
                    r_overflow  <= 1'b0;
                    r_clipped   <= 1'b0;
                end
                ACTIVE: begin
                    r_x         <= w_x_next;
                    r_y         <= w_y_eff;
                    r_line_base <= w_lb_eff;
                    if (w_take && !w_in_range) r_clipped <= 1'b1;
                    if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
                    if (i_vsync && !r_vsync_d) r_state <= DRAIN;
                end
                DRAIN: if (w_empty) begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= i_enable ? WAIT_FRAME : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed bench with a queue-based reference model checked every cycle.
module tb_frame_writer;
    localparam int H = 4, V = 2, AW = 18, D = 4;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, vsync = 1'b0, hsync = 1'b0, din_valid = 1'b0;
    logic [AW-1:0] frame_base = '0;
    logic [23:0] din = '0;
    logic frame_done, overflow, clipped, busy;
    int total = 0, bad = 0, nd = 0, pix_k = 0;
    logic [AW-1:0] wlog[$];
    logic [AW-1:0] exp_q[$];
    logic [31:0] dlog[$];
    int mstate = 0, mx = 0, my = 0;
    logic [AW-1:0] mbase = '0;
    bit mvs_d = 0, movf = 0, mclip = 0, mdone = 0, m_empty0 = 1;
    logic [AW+23:0] q[$];

    frame_writer_if #(.ADDR_W(AW)) avm ();
    frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .i_pclk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_frame_base(frame_base),
        .i_vsync(vsync), .i_hsync(hsync), .i_din(din), .i_din_valid(din_valid),
        .avm(avm), .o_frame_done(frame_done), .o_overflow(overflow),
        .o_clipped(clipped), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Reference model: pixel address is frame_base + y*H + x; the FIFO is a plain queue.
    task automatic model_step();
        if (!rst_n) begin
            mstate = 0; mx = 0; my = 0; mbase = '0; mvs_d = 0;
            movf = 0; mclip = 0; mdone = 0; q.delete();
        end else begin
            m_empty0 = (q.size() == 0);
            mdone = 0;
            if (!m_empty0 && !avm.waitrequest) void'(q.pop_front());
            case (mstate)
                0: if (enable && vsync) mstate = 1;
                1: if (mvs_d && !vsync) begin
                    mstate = 2; mx = 0; my = 0; mbase = frame_base; movf = 0; mclip = 0;
                end
                2: begin
                    if (hsync && mx != 0) begin my++; mx = 0; end
                    if (din_valid) begin
                        if (mx < H && my < V) begin
                            if (q.size() < D) q.push_back({mbase + AW'(my * H + mx), din});
                            else movf = 1;
                        end else mclip = 1;
                        if (mx < H) mx++;
                    end
                    if (vsync && !mvs_d) mstate = 3;
                end
                default: if (m_empty0) begin mdone = 1; mstate = enable ? 1 : 0; end
            endcase
            mvs_d = vsync;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("write", avm.write, q.size() != 0);
            if (q.size() != 0) begin
                chk("addr", avm.address, q[0][AW+23:24]);
                chk("data", avm.writedata, {8'h00, q[0][23:0]});
            end
            chk("frame_done", frame_done, mdone);
            chk("overflow", overflow, movf);
            chk("clipped", clipped, mclip);
            chk("busy", busy, mstate >= 2);
            if (avm.write && !avm.waitrequest) begin
                wlog.push_back(avm.address);
                dlog.push_back(avm.writedata);
            end
            if (frame_done) nd++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        frame_base = base;
        vsync = 1'b1;
        tick(); tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic hs();
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
    endtask

    task automatic pix(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din = 24'hA50000 | 24'(pix_k);
            pix_k++;
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic hs_pix();
        hsync = 1'b1;
        din_valid = 1'b1;
        din = 24'hA50000 | 24'(pix_k);
        pix_k++;
        tick();
        hsync = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic end_frame(input string n);
        int n0;
        n0 = nd;
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 40 && nd == n0; i++) tick();
        chk({n, "_done_seen"}, nd != n0, 1);
        repeat (4) tick();
        chk({n, "_done_once"}, nd - n0, 1);
    endtask

    task automatic clear();
        wlog.delete(); dlog.delete(); exp_q.delete(); pix_k = 0;
    endtask

    task automatic exp_seq(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + AW'(i));
    endtask

    task automatic check_log(input string n);
        chk({n, "_len"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            chk($sformatf("%s_addr%0d", n, i), wlog[i], exp_q[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        avm.waitrequest = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_write", avm.write, 0);
        chk("rst_addr", avm.address, 0);
        chk("rst_data", avm.writedata, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_clip", clipped, 0);
        chk("rst_busy", busy, 0);
        tick();

        // Two clean lines, no stalls.
        clear(); enable = 1'b1;
        start_frame(18'h100); hs(); pix(4); hs(); pix(4); end_frame("t1");
        exp_seq(18'h100, 8); check_log("t1");
        chk("t1_d0", dlog.size() > 0 ? dlog[0] : 32'h0, 32'h00A50000);
        chk("t1_d7", dlog.size() > 7 ? dlog[7] : 32'h0, 32'h00A50007);
        chk("t1_ovf", overflow, 0);
        chk("t1_clip", clipped, 0);

        // Ten-cycle stall: FIFO fills, two pixels of line 1 are dropped.
        clear();
        start_frame(18'h100); hs();
        avm.waitrequest = 1'b1;
        pix(4); hs(); pix(2); tick(); tick(); tick();
        chk("t2_ovf_mid", overflow, 1);
        avm.waitrequest = 1'b0;
        pix(2); end_frame("t2");
        exp_q = '{18'h100, 18'h101, 18'h102, 18'h103, 18'h106, 18'h107};
        check_log("t2");
        chk("t2_ovf", overflow, 1);
        chk("t2_clip", clipped, 0);

        // Overlong line and a third line are clipped.
        clear();
        start_frame(18'h100); hs(); pix(6);
        chk("t3_clip_mid", clipped, 1);
        hs(); pix(4); hs(); pix(2); end_frame("t3");
        exp_seq(18'h100, 8); check_log("t3");
        chk("t3_clip", clipped, 1);
        chk("t3_ovf", overflow, 0);

        // Repeated hsync at x=0 ignored; hsync with a pixel lands at x=0 of the next line.
        clear();
        start_frame(18'h100); hs(); hs(); pix(3); hs_pix(); pix(3); end_frame("t4");
        exp_q = '{18'h100, 18'h101, 18'h102, 18'h104, 18'h105, 18'h106, 18'h107};
        check_log("t4");
        chk("t4_d104", dlog.size() > 3 ? dlog[3] : 32'h0, 32'h00A50003);

        // Asynchronous reset during a stalled write.
        clear();
        start_frame(18'h100); hs();
        avm.waitrequest = 1'b1;
        pix(2);
        chk("t5_write_before", avm.write, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_write_async", avm.write, 0);
        chk("t5_busy_async", busy, 0);
        tick();
        rst_n = 1'b1;
        avm.waitrequest = 1'b0;
        tick();
        clear();
        start_frame(18'h100); hs(); pix(4); hs(); pix(4); end_frame("t5");
        exp_seq(18'h100, 8); check_log("t5");

        // Address wrap, enable dropped mid-frame, next frame ignored.
        clear();
        start_frame(18'h3FFFE);
        enable = 1'b0;
        hs(); pix(4); end_frame("t6");
        exp_q = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        check_log("t6");
        chk("t6_busy_idle", busy, 0);
        vsync = 1'b0;
        tick(); tick(); hs(); pix(2); tick();
        chk("t6_busy_after", busy, 0);
        chk("t6_no_writes", wlog.size(), 4);
        chk("t6_write_low", avm.write, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Downstream neighbour of the camera capture stage, in the same pclk domain.
- Takes RGB888 pixels, one per-pixel strobe at a time, plus frame/line sync, and computes the linear frame-buffer address of each pixel.
- Buffers pixels in a small FIFO and writes them to SDRAM/on-chip memory through an Avalon-MM-style write master with waitrequest back-pressure.
- Reports frame completion, overflow and clipping to the control logic.

Parameters:
- H_ACTIVE, 640, pixels per line; x range 0..H_ACTIVE-1.
- V_ACTIVE, 480, lines per frame; y range 0..V_ACTIVE-1.
- ADDR_W, 20, word-address width of the memory port.
- FIFO_DEPTH, 8, pixel FIFO entries; must be a power of 2, ≥2.

Ports:
- pclk  in  1  pixel clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  arm capture; sampled only at frame boundaries.
- frame_base  in  ADDR_W  word address of pixel (0,0); latched at frame start.
- vsync  in  1  high during vertical blanking.
- hsync  in  1  one-cycle pulse at start of each line.
- din  in  24  pixel {R8,G8,B8}.
- din_valid  in  1  one-cycle strobe; din is valid this cycle.
- avm_address  out  ADDR_W  write word address.
- avm_writedata  out  32  {8'h00, din}.
- avm_write  out  1  write request.
- avm_waitrequest  in  1  slave stall.
- frame_done  out  1  one-cycle pulse when the last write of a frame completes.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- clipped  out  1  sticky; a pixel fell outside H_ACTIVE×V_ACTIVE and was dropped.
- busy  out  1  high in ACTIVE or DRAIN.

Behaviour:
- Reset state: FSM=IDLE; FIFO empty; x=y=0; line_base=0. All outputs 0: avm_address, avm_writedata, avm_write, frame_done, overflow, clipped, busy.
- IDLE → WAIT_FRAME when enable=1 and vsync=1.
- WAIT_FRAME → ACTIVE on vsync falling edge (vsync_d=1, vsync=0). On that transition:
  - x=0, y=0, line_base=frame_base;
  - overflow and clipped cleared.
- ACTIVE:
  - hsync with x≠0: y←y+1, x←0, line_base←line_base+H_ACTIVE. hsync with x=0 is ignored (first line, or a repeated pulse).
  - If hsync and din_valid occur in the same cycle, the line advance applies first; the pixel lands at x=0 of the new line.
  - din_valid with x<H_ACTIVE and y<V_ACTIVE (after any advance): push {line_base+x, din} into the FIFO, then x←x+1.
  - Out-of-range pixel: dropped, clipped←1; x still increments, saturating at H_ACTIVE.
  - FIFO full on an accepted pixel: pixel dropped, overflow←1, x still increments.
  - No multiplier; address = line_base + x, computed in ADDR_W bits and wrapping modulo 2^ADDR_W.
  - vsync rising → DRAIN. The pixel strobe in that same cycle is still accepted.
- DRAIN:
  - Input pixels are ignored.
  - When the FIFO is empty and avm_write=0: frame_done=1 for one cycle.
  - Next state is WAIT_FRAME if enable=1, else IDLE.
- Write master (every state):
  - Head of FIFO drives avm_address/avm_writedata; avm_write=1 while the FIFO is non-empty.
  - Pop occurs on avm_write & !avm_waitrequest.
  - Address and data must stay stable while waitrequest=1.
  - Minimum latency: din_valid in cycle N → avm_write=1 in cycle N+1 (registered FIFO output).
  - Full throughput: one pixel/cycle in and out, with simultaneous push/pop when full-with-pop allowed only if pop occurs the same cycle.
- busy = (state==ACTIVE) | (state==DRAIN).
- enable falling mid-frame has no effect until DRAIN completes.
- rst_n low mid-frame: immediate return to reset state; in-flight write abandoned and avm_write drops asynchronously.

Decomposition:
- Package frame_writer_pkg:
  - state enum: IDLE, WAIT_FRAME, ACTIVE, DRAIN;
  - PIX_W=24, DATA_W=32;
  - FIFO entry width function ADDR_W+PIX_W.
- Sub-module pix_fifo:
  - synchronous FIFO, parameterised WIDTH/DEPTH;
  - push, pop, full, empty, registered head output;
  - same-cycle push/pop supported when full.
- FSM, counters and Avalon master stay in frame_writer.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, frame_base=0x100 unless noted):
1. enable=1, vsync 1→0, then 2 lines of 4 strobes each, with hsync before each line, waitrequest=0 → writes to 0x100..0x103 and 0x104..0x107 with matching data. After vsync rises: frame_done pulses once; overflow=0, clipped=0.
2. As in 1, but waitrequest held high for 10 cycles during line 0 → first 4 pixels buffered, next dropped, overflow=1. avm_address/avm_writedata stay stable while stalled. Write sequence resumes in order.
3. 6 strobes in one line → 0x100..0x103 written, 2 pixels dropped, clipped=1. Third line in the frame → dropped, clipped stays 1.
4. hsync and din_valid in the same cycle, with x=3 on line 0 → that pixel is written at 0x104. Second hsync with x=0 → no y advance.
5. rst_n pulsed low while avm_write=1 and waitrequest=1 → avm_write=0 immediately, FSM IDLE. Next full frame writes correctly from 0x100.
6. enable=0 during ACTIVE, frame_base=0x3FFFE, ADDR_W=18 → addresses wrap to 0x3FFFE, 0x3FFFF, 0x00000, 0x00001. After frame_done: state IDLE, busy=0, and the next vsync falling edge is ignored.
